// File: rtl/stream_pattern_tester.sv
// Traffic generator and checker for the ftdi_245fifo user streams: drives TX with a
// selectable pattern (INC / LFSR / TOGGLE), checks RX against the same pattern family.
module stream_pattern_tester #(
   parameter int TX_DW    = 64,
   parameter int RX_DW    = 8,
   parameter int LED_HOLD = 50000000,
   parameter int LOCK_N   = 16
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             restart,
   input  logic [1:0]       mode,
   input  logic             tx_en,
   input  logic [7:0]       tx_gap,
   output logic             tx_valid,
   input  logic             tx_ready,
   output logic [TX_DW-1:0] tx_data,
   input  logic             rx_en,
   input  logic             rx_valid,
   output logic             rx_ready,
   input  logic [RX_DW-1:0] rx_data,
   output logic [31:0]      tx_cnt,
   output logic [31:0]      rx_cnt,
   output logic [15:0]      err_cnt,
   output logic             led,
   output logic             locked
);

   localparam int                 LED_W    = $clog2(LED_HOLD + 1);
   localparam logic [LED_W-1:0]   LED_LOAD = LED_W'(LED_HOLD);
   localparam logic [LED_W-1:0]   LED_ONE  = LED_W'(1);
   localparam logic [15:0]        LOCK_TH  = 16'(LOCK_N);
   localparam logic [TX_DW-1:0]   TX_ONE   = TX_DW'(1);
   localparam logic [RX_DW-1:0]   RX_ONE   = RX_DW'(1);

   typedef enum logic [1:0] {IDLE, SEND, GAP} gen_state_t;

   gen_state_t       state;
   logic [7:0]       gap_cnt;
   logic [1:0]       mode_q;
   logic             seeded;
   logic [RX_DW-1:0] exp_data;
   logic [15:0]      good_cnt;
   logic [LED_W-1:0] led_cnt;
   logic             rx_hs;

   function automatic logic [TX_DW-1:0] tx_next(input logic [1:0] m, input logic [TX_DW-1:0] w);
      logic [TX_DW-1:0] r;
      case (m)
         2'd1: begin
            r = {w[TX_DW-2:0], w[TX_DW-1] ^ w[TX_DW-2]};
            if (r == '0) r = TX_ONE;
         end
         2'd2:    r = ~w;
         default: r = w + TX_ONE;
      endcase
      return r;
   endfunction

   function automatic logic [RX_DW-1:0] rx_next(input logic [1:0] m, input logic [RX_DW-1:0] w);
      logic [RX_DW-1:0] r;
      case (m)
         2'd1: begin
            r = {w[RX_DW-2:0], w[RX_DW-1] ^ w[RX_DW-2]};
            if (r == '0) r = RX_ONE;
         end
         2'd2:    r = ~w;
         default: r = w + RX_ONE;
      endcase
      return r;
   endfunction

   function automatic logic [TX_DW-1:0] tx_seed(input logic [1:0] m);
      return (m == 2'd1) ? TX_ONE : '0;
   endfunction

   assign rx_ready = rx_en;
   assign rx_hs    = rx_valid & rx_en;
   assign led      = (led_cnt != '0);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) mode_q <= 2'd0;
      else if (restart) mode_q <= mode;
   end

   // Generator: tx_valid is only dropped after a completed handshake
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= IDLE;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         tx_cnt   <= '0;
         gap_cnt  <= '0;
      end else if (restart) begin
         state    <= IDLE;
         tx_valid <= 1'b0;
         tx_data  <= tx_seed(mode);
         tx_cnt   <= '0;
         gap_cnt  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (tx_en) begin
                  state    <= SEND;
                  tx_valid <= 1'b1;
               end
            end
            SEND: begin
               if (tx_ready) begin
                  tx_data <= tx_next(mode_q, tx_data);
                  tx_cnt  <= tx_cnt + 32'd1;
                  if (tx_gap != 8'd0) begin
                     state    <= GAP;
                     tx_valid <= 1'b0;
                     gap_cnt  <= tx_gap;
                  end else if (!tx_en) begin
                     state    <= IDLE;
                     tx_valid <= 1'b0;
                  end
               end
            end
            GAP: begin
               if (gap_cnt <= 8'd1) begin
                  state    <= tx_en ? SEND : IDLE;
                  tx_valid <= tx_en;
               end else begin
                  gap_cnt <= gap_cnt - 8'd1;
               end
            end
            default: begin
               state    <= IDLE;
               tx_valid <= 1'b0;
            end
         endcase
      end
   end

   // Checker: resynchronises on every accepted word; the first word only seeds
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rx_cnt   <= '0;
         err_cnt  <= '0;
         good_cnt <= '0;
         led_cnt  <= '0;
         locked   <= 1'b0;
         seeded   <= 1'b0;
         exp_data <= '0;
      end else if (restart) begin
         rx_cnt   <= '0;
         err_cnt  <= '0;
         good_cnt <= '0;
         led_cnt  <= '0;
         locked   <= 1'b0;
         seeded   <= 1'b0;
         exp_data <= '0;
      end else begin
         if (led_cnt != '0) led_cnt <= led_cnt - LED_ONE;
         if (rx_hs) begin
            rx_cnt   <= rx_cnt + 32'd1;
            exp_data <= rx_next(mode_q, rx_data);
            seeded   <= 1'b1;
            if (seeded) begin
               if (rx_data != exp_data) begin
                  if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
                  led_cnt  <= LED_LOAD;
                  good_cnt <= '0;
                  locked   <= 1'b0;
               end else begin
                  if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 16'd1;
                  if (good_cnt >= LOCK_TH - 16'd1) locked <= 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_pattern_tester.sv
// Randomised and directed bench for stream_pattern_tester against a behavioural
// model of the pattern generator/checker rules.
module tb_stream_pattern_tester;

   localparam int TXW   = 64;
   localparam int RXW   = 8;
   localparam int HOLD  = 20;
   localparam int LOCKN = 2;

   logic            clk;
   logic            rstn;
   logic            restart;
   logic [1:0]      mode;
   logic            tx_en;
   logic [7:0]      tx_gap;
   logic            tx_valid;
   logic            tx_ready;
   logic [TXW-1:0]  tx_data;
   logic            rx_en;
   logic            rx_valid;
   logic            rx_ready;
   logic [RXW-1:0]  rx_data;
   logic [31:0]     tx_cnt;
   logic [31:0]     rx_cnt;
   logic [15:0]     err_cnt;
   logic            led;
   logic            locked;

   stream_pattern_tester #(
      .TX_DW(TXW), .RX_DW(RXW), .LED_HOLD(HOLD), .LOCK_N(LOCKN)
   ) dut (
      .clk(clk), .rstn(rstn), .restart(restart), .mode(mode),
      .tx_en(tx_en), .tx_gap(tx_gap), .tx_valid(tx_valid), .tx_ready(tx_ready),
      .tx_data(tx_data), .rx_en(rx_en), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .rx_data(rx_data), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .err_cnt(err_cnt),
      .led(led), .locked(locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", tag, got, want);
   endtask

   // Behavioural model state
   int             m_mode;
   logic [63:0]    m_word;
   bit             m_valid;
   int             m_gapleft;
   logic [31:0]    m_txcnt;
   logic [31:0]    m_rxcnt;
   int             m_err;
   int             m_good;
   bit             m_locked;
   int             m_led;
   bit             m_seeded;
   logic [63:0]    m_exp;

   function automatic logic [63:0] ref_nxt(input int md, input logic [63:0] v, input int w);
      logic [63:0] mask;
      logic [63:0] r;
      mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
      case (md)
         1: begin
            r = ((v << 1) | (((v >> (w - 1)) ^ (v >> (w - 2))) & 64'd1)) & mask;
            if (r == 64'd0) r = 64'd1;
         end
         2:       r = ~v & mask;
         default: r = (v + 64'd1) & mask;
      endcase
      return r;
   endfunction

   function automatic logic [63:0] ref_seed(input int md);
      return (md == 1) ? 64'd1 : 64'd0;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_word = 0; m_valid = 0; m_gapleft = 0;
      m_txcnt = 0; m_rxcnt = 0; m_err = 0; m_good = 0;
      m_locked = 0; m_led = 0; m_seeded = 0; m_exp = 0;
   endtask

   task automatic model_edge();
      if (!rstn) begin
         model_reset();
         return;
      end
      if (m_led > 0) m_led--;
      if (restart) begin
         m_mode = int'(mode); m_word = ref_seed(m_mode); m_valid = 0; m_gapleft = 0;
         m_txcnt = 0; m_rxcnt = 0; m_err = 0; m_good = 0;
         m_locked = 0; m_led = 0; m_seeded = 0;
         return;
      end
      if (m_valid) begin
         if (tx_ready) begin
            m_word = ref_nxt(m_mode, m_word, TXW);
            m_txcnt++;
            if (tx_gap != 0) begin
               m_valid = 0;
               m_gapleft = int'(tx_gap);
            end else begin
               m_valid = tx_en;
            end
         end
      end else if (m_gapleft > 1) begin
         m_gapleft--;
      end else begin
         m_gapleft = 0;
         m_valid = tx_en;
      end
      if (rx_valid && rx_en) begin
         m_rxcnt++;
         if (m_seeded) begin
            if (64'(rx_data) != m_exp) begin
               if (m_err < 65535) m_err++;
               m_led = HOLD;
               m_good = 0;
               m_locked = 0;
            end else begin
               if (m_good < 65535) m_good++;
               if (m_good >= LOCKN) m_locked = 1;
            end
         end
         m_seeded = 1;
         m_exp = ref_nxt(m_mode, 64'(rx_data), RXW);
      end
   endtask

   task automatic compare_all();
      chk_eq("tx_valid", tx_valid, m_valid);
      chk_eq("tx_data", tx_data, m_word);
      chk_eq("tx_cnt", tx_cnt, m_txcnt);
      chk_eq("rx_cnt", rx_cnt, m_rxcnt);
      chk_eq("err_cnt", err_cnt, m_err);
      chk_eq("led", led, m_led != 0);
      chk_eq("locked", locked, m_locked);
      chk_eq("rx_ready", rx_ready, rx_en);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_edge();
      #1;
      compare_all();
   endtask

   task automatic do_restart(input logic [1:0] md);
      mode = md;
      restart = 1'b1;
      cycle();
      restart = 1'b0;
   endtask

   logic [RXW-1:0] words4 [6]  = '{8'd5, 8'd6, 8'd7, 8'd9, 8'd10, 8'd11};
   bit             lock4  [6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   logic [RXW-1:0] words5 [9]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h81, 8'h03};
   bit             gap_pat [8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

   initial begin
      int hcount;
      logic [RXW-1:0] r_last;

      rstn = 1'b0; restart = 1'b0; mode = 2'd0; tx_en = 1'b0; tx_gap = 8'd0;
      tx_ready = 1'b1; rx_en = 1'b0; rx_valid = 1'b0; rx_data = '0;
      model_reset();
      repeat (2) cycle();
      chk_eq("rst_tx_valid", tx_valid, 0);
      chk_eq("rst_tx_data", tx_data, 0);
      chk_eq("rst_led", led, 0);
      chk_eq("rst_locked", locked, 0);
      rstn = 1'b1;
      cycle();

      // INC back-to-back
      tx_en = 1'b1;
      cycle();
      chk_eq("tx_rise", tx_valid, 1);
      for (int i = 0; i < 10; i++) begin
         chk_eq("inc_data", tx_data, i);
         cycle();
      end
      chk_eq("inc_cnt", tx_cnt, 10);

      // Stall with tx_en dropped
      do_restart(2'd0);
      cycle();
      repeat (3) cycle();
      chk_eq("stall_pre", tx_data, 3);
      tx_ready = 1'b0;
      tx_en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk_eq("stall_valid", tx_valid, 1);
         chk_eq("stall_data", tx_data, 3);
      end
      tx_ready = 1'b1;
      cycle();
      chk_eq("stall_done_valid", tx_valid, 0);
      chk_eq("stall_done_cnt", tx_cnt, 4);
      cycle();
      chk_eq("stall_idle", tx_valid, 0);

      // Gap of 3
      tx_gap = 8'd3;
      tx_en = 1'b1;
      cycle();
      for (int i = 0; i < 8; i++) begin
         if (i > 0) cycle();
         chk_eq("gap_pattern", tx_valid, gap_pat[i]);
      end
      tx_gap = 8'd0;
      do_restart(2'd2);
      chk_eq("tog_seed", tx_data, 0);
      cycle();
      chk_eq("tog_0", tx_data, 0);
      cycle();
      chk_eq("tog_1", tx_data, 64'hFFFF_FFFF_FFFF_FFFF);
      cycle();
      chk_eq("tog_2", tx_data, 0);
      tx_en = 1'b0;
      repeat (6) cycle();

      // RX INC with one error
      do_restart(2'd0);
      rx_en = 1'b1;
      rx_valid = 1'b1;
      hcount = 0;
      for (int i = 0; i < 6; i++) begin
         rx_data = words4[i];
         cycle();
         chk_eq("rx_locked", locked, lock4[i]);
         if (i >= 3) hcount += int'(led);
      end
      rx_valid = 1'b0;
      repeat (25) begin
         cycle();
         hcount += int'(led);
      end
      chk_eq("rx_err1", err_cnt, 1);
      chk_eq("led_hold", hcount, HOLD);
      chk_eq("led_off", led, 0);

      // RX LFSR
      do_restart(2'd1);
      rx_valid = 1'b1;
      for (int i = 0; i < 9; i++) begin
         rx_data = words5[i];
         cycle();
      end
      rx_valid = 1'b0;
      chk_eq("lfsr_err", err_cnt, 0);
      chk_eq("lfsr_cnt", rx_cnt, 9);

      // Error saturation, then restart colliding with a handshake
      do_restart(2'd0);
      rx_valid = 1'b1;
      rx_data = '0;
      repeat (65541) cycle();
      chk_eq("err_sat", err_cnt, 16'hFFFF);
      rx_data = 8'h55;
      restart = 1'b1;
      cycle();
      restart = 1'b0;
      chk_eq("rst_hs_rx", rx_cnt, 0);
      chk_eq("rst_hs_err", err_cnt, 0);
      rx_data = 8'h10;
      cycle();
      chk_eq("seed_cnt", rx_cnt, 1);
      chk_eq("seed_err", err_cnt, 0);
      rx_data = 8'h12;
      cycle();
      chk_eq("seed_cmp", err_cnt, 1);
      rx_valid = 1'b0;

      // Randomised traffic
      r_last = '0;
      for (int c = 0; c < 3000; c++) begin
         restart  = ($urandom_range(0, 199) == 0);
         mode     = 2'($urandom_range(0, 3));
         tx_en    = ($urandom_range(0, 3) != 0);
         tx_ready = ($urandom_range(0, 2) != 0);
         tx_gap   = ($urandom_range(0, 1) == 0) ? 8'd0 : 8'($urandom_range(1, 4));
         rx_en    = ($urandom_range(0, 3) != 0);
         rx_valid = ($urandom_range(0, 2) != 0);
         rx_data  = ($urandom_range(0, 7) != 0) ? RXW'(ref_nxt(m_mode, 64'(r_last), RXW))
                                                : RXW'($urandom);
         if (rx_valid && rx_en) r_last = rx_data;
         cycle();
      end
      restart = 1'b0;

      // Asynchronous reset in the middle of traffic
      tx_en = 1'b1; tx_ready = 1'b1; tx_gap = 8'd0; rx_en = 1'b1; rx_valid = 1'b1;
      repeat (4) cycle();
      rstn = 1'b0;
      #1;
      model_reset();
      compare_all();
      chk_eq("arst_tx_valid", tx_valid, 0);
      chk_eq("arst_tx_cnt", tx_cnt, 0);
      cycle();
      rstn = 1'b1;
      repeat (5) cycle();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/stream_pattern_tester.md
# stream_pattern_tester

Parametrised single-clock traffic generator and checker for the `ftdi_245fifo` user-side streams. It replaces per-board hand-written incrementing-data example logic. It drives the TX stream with a selectable pattern, optionally throttled, and checks the RX stream against the same pattern family. It reports counts, error totals, a stretched error LED and a lock flag, and sits between board top-level glue and `ftdi_245fifo`.

## Interface
Parameters:
- `TX_DW`, 64, TX word width in bits; multiple of 8, >= 8
- `RX_DW`, 8, RX word width in bits; multiple of 8, >= 8
- `LED_HOLD`, 50000000, cycles `led` stays high after the last error; >= 1
- `LOCK_N`, 16, consecutive good RX words required to assert `locked`; 1..65535

Ports:
- `clk`  in  1  single clock for all logic
- `rstn`  in  1  reset, asynchronous, active-low
- `restart`  in  1  synchronous one-cycle pulse: reseed generator/checker, clear counters, latch `mode`
- `mode`  in  2  pattern select: 0=INC, 1=LFSR, 2=TOGGLE, 3=INC; sampled only on `restart`
- `tx_en`  in  1  permit new TX words
- `tx_gap`  in  8  idle cycles inserted after each TX handshake
- `tx_valid`  out  1  TX stream valid
- `tx_ready`  in  1  TX stream ready
- `tx_data`  out  TX_DW  TX stream data
- `rx_en`  in  1  permit RX acceptance
- `rx_valid`  in  1  RX stream valid
- `rx_ready`  out  1  RX stream ready
- `rx_data`  in  RX_DW  RX stream data
- `tx_cnt`  out  32  accepted TX words, wraps
- `rx_cnt`  out  32  accepted RX words, wraps
- `err_cnt`  out  16  RX mismatches, saturates at 0xFFFF
- `led`  out  1  high while the error hold counter is nonzero
- `locked`  out  1  checker has seen `LOCK_N` consecutive matches

## Operation
- Pattern successor function `nxt(w)` for width W:
  - INC: w+1 mod 2^W.
  - LFSR: {w[W-2:0], w[W-1]^w[W-2]}, with a result of 0 replaced by 1.
  - TOGGLE: ~w.
- Seed: 1 for LFSR, 0 for INC and TOGGLE.
- `mode_q` resets to 0 (INC). It loads `mode` only on `restart`. Software sets `mode` and then pulses `restart`.
- Generator:
  - FSM with states IDLE, SEND, GAP.
  - IDLE: `tx_valid`=0. If `tx_en`, go to SEND.
  - SEND: `tx_valid`=1, `tx_data` stable. On `tx_valid&tx_ready`: `tx_data`<=nxt(`tx_data`) and `tx_cnt`++. Then go to GAP if `tx_gap`!=0, else to SEND if `tx_en`, else IDLE.
  - GAP: counts `tx_gap` cycles (value captured at the handshake). At expiry go to SEND if `tx_en`, else IDLE.
  - Deasserting `tx_en` never drops an asserted `tx_valid`; the word in flight completes.
- Checker:
  - `rx_ready` = `rx_en` (combinational).
  - Each RX handshake: `rx_cnt`++, and `exp`<=nxt(`rx_data`), i.e. it re-synchronises on every word.
  - The first word after reset or `restart` only seeds `exp`; it is not compared.
  - Every later word: if `rx_data`!=`exp`, then `err_cnt`++ (saturating), the LED counter loads `LED_HOLD`, the good-run counter clears, and `locked`<=0. Otherwise the good-run counter increments (saturating), and `locked`<=1 when it reaches `LOCK_N`.
- LED counter decrements by 1 every cycle while nonzero. `led` = (counter != 0). An error reload takes priority over the decrement.
- `restart` (highest priority, overrides same-cycle handshakes):
  - FSM to IDLE, `tx_valid`=0, `tx_data`=seed(`mode`).
  - `tx_cnt`, `rx_cnt`, `err_cnt`, good-run counter, LED counter, `locked` cleared.
  - Checker returns to seed-pending.
  - A handshake coinciding with `restart` is not counted.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, all counters 0, `led`=0, `locked`=0. `rx_ready` follows `rx_en`.
- After reset release, `tx_valid` rises 1 cycle after `tx_en` is sampled high (IDLE->SEND).
- With `tx_gap`=0 and `tx_ready`=1, the generator sends back-to-back, one word per cycle.
- With `tx_gap`=N, consecutive `tx_valid` high cycles are separated by exactly N low cycles.
- All counters, `err_cnt`, `led` and `locked` update on the clock edge that completes the handshake, visible the next cycle.
- An asynchronous `rstn` assertion mid-transfer clears everything immediately. Behaviour after release is identical to power-up.

## Test plan
- Reset, `tx_en`=1, `tx_gap`=0, `tx_ready`=1, INC, TX_DW=64 -> `tx_data` 0,1,2,…,9 on consecutive cycles; `tx_cnt`=10 after 10 handshakes.
- `tx_ready` low for 5 cycles while `tx_data`=3; drop `tx_en` during the stall -> `tx_valid` and data 3 held; word 3 completes when ready returns; then IDLE.
- `tx_gap`=3 -> `tx_valid` pattern 1,0,0,0,1,0,0,0; `restart` with `mode`=2 -> data 0, all-ones, 0, …
- RX INC, LED_HOLD=20, LOCK_N=2: words 5,6,7,9,10,11 -> `err_cnt`=1; `led` high for exactly 20 cycles after the error; `locked` high after 7, low after 9, high again after 11.
- RX_DW=8, `restart` with `mode`=1; RX 0x01,0x02,0x04,…,0x40,0x81,0x03 -> `err_cnt`=0, `rx_cnt`=9.
- Force 65540 mismatches -> `err_cnt`=0xFFFF; `restart` coincident with an RX handshake -> all counters 0, and the next word only seeds the checker.
